stopwatch_calc_ctrl: RTL and testbench

STOPWATCH_CALC_CTRL -- requirements
Module: stopwatch_calc_ctrl

---
 rtl/disp_pkg.sv | 33 +++
 rtl/bin2bcd_seq.sv | 83 ++++++++
 rtl/stopwatch_calc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_calc_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared codes for the stopwatch/calculator display controller: digit and key
// codes, the mode and counter-command enums, and a constant power-of-ten helper.
package disp_pkg;

  localparam logic [3:0] DIG_MINUS  = 4'd10;
  localparam logic [3:0] DIG_BLANK  = 4'd11;

  localparam logic [3:0] KEY_CLEAR  = 4'd10;
  localparam logic [3:0] KEY_START  = 4'd11;
  localparam logic [3:0] KEY_STOP   = 4'd12;
  localparam logic [3:0] KEY_SW_LAP = 4'd13;
  localparam logic [3:0] KEY_CALC_A = 4'd14;
  localparam logic [3:0] KEY_CALC_B = 4'd15;

  typedef enum logic {
    MODE_CALC = 1'b0,
    MODE_SW   = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    SW_HOLD  = 2'b00,
    SW_RUN   = 2'b01,
    SW_CLEAR = 2'b10
  } sw_ctrl_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one load cycle, then WIDTH shift cycles;
// done pulses after the last shift with the BCD result held stable.
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                           : bcd_q[gi*4 +: 4];
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      // A bit carried out of the top digit means the value needs more digits.
      ovf_d = ovf_q | bcd_adj[DIGITS*4-1];
      bcd_d = {bcd_adj[DIGITS*4-2:0], bin_q[WIDTH-1]};
      bin_d = {bin_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      bin_d  = bin_in;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/stopwatch_calc_ctrl.sv
// Keypad-driven mode/stopwatch controller with a continuously refreshed
// seven-segment digit display fed by a sequential binary-to-BCD converter.
module stopwatch_calc_ctrl
  import disp_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 32,
  parameter int LZB    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  input  logic [WIDTH-1:0]     sw_count,
  input  logic [WIDTH-1:0]     calc_result,
  input  logic                 calc_neg,
  output logic [1:0]           sw_ctrl,
  output logic                 mode,
  output logic                 lap,
  output logic [DIGITS*4-1:0]  digits,
  output logic                 busy,
  output logic                 upd
);

  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(pow10(DIGITS) - 64'd1);
  localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(pow10(DIGITS - 1) - 64'd1);
  localparam logic [DIGITS*4-1:0] ALL_BLANK = {DIGITS{DIG_BLANK}};
  localparam logic [DIGITS*4-1:0] ALL_MINUS = {DIGITS{DIG_MINUS}};

  mode_t               mode_q, mode_d;
  sw_ctrl_t            sw_ctrl_q, sw_ctrl_d;
  logic                lap_q, lap_d;
  logic [WIDTH-1:0]    lap_reg_q, lap_reg_d;
  logic                neg_q, neg_d;
  logic                big_q, big_d;
  logic [DIGITS*4-1:0] digits_q, digits_d;
  logic                upd_q, upd_d;

  logic                conv_busy, conv_done, conv_ovf, start, abort;
  logic [DIGITS*4-1:0] conv_bcd, fmt;
  logic [WIDTH-1:0]    src_mag;
  logic                src_neg, seen;

  // Key handling and mode FSM.
  always_comb begin
    mode_d    = mode_q;
    sw_ctrl_d = (sw_ctrl_q == SW_CLEAR) ? SW_HOLD : sw_ctrl_q;
    lap_d     = lap_q;
    lap_reg_d = lap_reg_q;
    if (key_valid) begin
      case (mode_q)
        MODE_CALC: begin
          if (key_code == KEY_SW_LAP) mode_d = MODE_SW;
        end
        MODE_SW: begin
          if (key_code == KEY_CALC_A || key_code == KEY_CALC_B) begin
            mode_d    = MODE_CALC;
            sw_ctrl_d = SW_HOLD;
            lap_d     = 1'b0;
          end else if (key_code == KEY_START) begin
            sw_ctrl_d = SW_RUN;
          end else if (key_code == KEY_STOP) begin
            sw_ctrl_d = SW_HOLD;
          end else if (key_code == KEY_CLEAR) begin
            sw_ctrl_d = SW_CLEAR;
            lap_d     = 1'b0;
          end else if (key_code == KEY_SW_LAP) begin
            lap_d = ~lap_q;
            if (!lap_q) lap_reg_d = sw_count;
          end
        end
        default: mode_d = MODE_CALC;
      endcase
    end
  end

  // The source is taken from current state, so a key landing on the load
  // cycle only affects the next sample.
  always_comb begin
    src_mag = calc_result;
    src_neg = calc_neg;
    if (mode_q == MODE_SW) begin
      src_mag = lap_q ? lap_reg_q : sw_count;
      src_neg = 1'b0;
    end
  end

  assign start = ~conv_busy;
  assign abort = conv_busy & (mode_d != mode_q);

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .bin_in (src_mag),
    .busy   (conv_busy),
    .done   (conv_done),
    .ovf    (conv_ovf),
    .bcd    (conv_bcd)
  );

  // Sign, overflow and leading-zero blanking of the finished conversion.
  always_comb begin
    fmt  = conv_bcd;
    seen = 1'b0;
    if (big_q || conv_ovf) begin
      fmt = ALL_MINUS;
    end else begin
      if (neg_q) fmt[(DIGITS-1)*4 +: 4] = DIG_MINUS;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (!(neg_q && i == DIGITS - 1)) begin
          if (conv_bcd[i*4 +: 4] != 4'd0) seen = 1'b1;
          else if (LZB != 0 && !seen) fmt[i*4 +: 4] = DIG_BLANK;
        end
      end
    end
  end

  always_comb begin
    neg_d    = neg_q;
    big_d    = big_q;
    digits_d = digits_q;
    upd_d    = 1'b0;
    if (start) begin
      neg_d = src_neg;
      big_d = src_neg ? (src_mag > MAX_NEG) : (src_mag > MAX_POS);
    end
    if (abort) begin
      digits_d = ALL_BLANK;
    end else if (conv_done) begin
      digits_d = fmt;
      upd_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_CALC;
      sw_ctrl_q <= SW_HOLD;
      lap_q     <= 1'b0;
      lap_reg_q <= '0;
      neg_q     <= 1'b0;
      big_q     <= 1'b0;
      digits_q  <= ALL_BLANK;
      upd_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      sw_ctrl_q <= sw_ctrl_d;
      lap_q     <= lap_d;
      lap_reg_q <= lap_reg_d;
      neg_q     <= neg_d;
      big_q     <= big_d;
      digits_q  <= digits_d;
      upd_q     <= upd_d;
    end
  end

  assign sw_ctrl = sw_ctrl_q;
  assign mode    = mode_q;
  assign lap     = lap_q;
  assign digits  = digits_q;
  assign busy    = conv_busy;
  assign upd     = upd_q;

endmodule

// File: tb/tb_stopwatch_calc_ctrl.sv
// Scoreboard bench for stopwatch_calc_ctrl at default parameters (4 digits,
// 32-bit values, blanking on).
module tb_stopwatch_calc_ctrl;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_code = 4'd0;
  logic [W-1:0]  sw_count = '0;
  logic [W-1:0]  calc_result = '0;
  logic          calc_neg = 1'b0;
  logic [1:0]    sw_ctrl;
  logic          mode, lap, busy, upd;
  logic [D*4-1:0] digits;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  stopwatch_calc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .sw_count    (sw_count),
    .calc_result (calc_result),
    .calc_neg    (calc_neg),
    .sw_ctrl     (sw_ctrl),
    .mode        (mode),
    .lap         (lap),
    .digits      (digits),
    .busy        (busy),
    .upd         (upd)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Independent reference: decimal digits by division, then sign/overflow/blanking.
  function automatic logic [15:0] model(input longint unsigned mag, input bit neg);
    logic [3:0] dg [D];
    logic [15:0] r;
    int nd;
    bit nz;
    longint unsigned v;
    if ((!neg && mag > 9999) || (neg && mag > 999)) return 16'hAAAA;
    v = mag;
    for (int i = 0; i < D; i++) begin
      dg[i] = 4'(v % 10);
      v = v / 10;
    end
    nd = neg ? D - 1 : D;
    nz = 1'b0;
    for (int i = nd - 1; i >= 1; i--) begin
      if (dg[i] != 4'd0) nz = 1'b1;
      else if (!nz) dg[i] = 4'd11;
    end
    if (neg) dg[D-1] = 4'd10;
    r = {dg[3], dg[2], dg[1], dg[0]};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_upd();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (upd) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("upd_timeout", {63'd0, upd}, 64'd1);
  endtask

  // Counts edges from now until upd; returns the edge index on which it appeared.
  task automatic edges_to_upd(output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (upd) begin
        n = k;
        break;
      end
    end
  endtask

  // Second upd after the stimulus is guaranteed to come from a post-stimulus sample.
  task automatic run_vec(input string tag, input logic [15:0] exp);
    logic [15:0] e;
    exp_q.push_back(exp);
    wait_upd();
    wait_upd();
    e = exp_q.pop_front();
    check(tag, 64'(digits), 64'(e));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mode"},    64'(mode),    64'd0);
    check({pfx, "_sw_ctrl"}, 64'(sw_ctrl), 64'd0);
    check({pfx, "_lap"},     64'(lap),     64'd0);
    check({pfx, "_busy"},    64'(busy),    64'd0);
    check({pfx, "_upd"},     64'(upd),     64'd0);
    check({pfx, "_digits"},  64'(digits),  64'hBBBB);
  endtask

  initial begin
    int n;
    logic [15:0] e;

    calc_result = 32'd42;
    repeat (3) tick();
    check_reset_outputs("rst");

    // First load on the first edge after release; upd on edge W+2.
    exp_q.push_back(model(42, 0));
    rst_n = 1'b1;
    edges_to_upd(n);
    check("first_upd_latency", 64'(n), 64'(W + 2));
    e = exp_q.pop_front();
    check("calc_42", 64'(digits), 64'(e));
    tick();
    check("upd_one_cycle", 64'(upd), 64'd0);

    calc_result = 32'd7;    calc_neg = 1'b1;
    run_vec("calc_neg7", model(7, 1));
    calc_result = 32'd1000; calc_neg = 1'b1;
    run_vec("calc_neg_ovf", model(1000, 1));
    calc_result = 32'd999;  calc_neg = 1'b1;
    run_vec("calc_neg999", model(999, 1));
    calc_result = 32'd0;    calc_neg = 1'b0;
    run_vec("calc_zero", model(0, 0));
    calc_result = 32'd9999;
    run_vec("calc_9999", model(9999, 0));
    calc_result = 32'd10000;
    run_vec("calc_ovf", model(10000, 0));

    press(4'd11);
    check("calc_ignore_start", 64'(sw_ctrl), 64'd0);
    check("calc_ignore_mode", 64'(mode), 64'd0);

    press(4'd13);
    check("enter_sw_mode", 64'(mode), 64'd1);
    press(4'd11);
    check("sw_run", 64'(sw_ctrl), 64'd1);
    sw_count = 32'd1234;
    run_vec("sw_1234", model(1234, 0));
    sw_count = 32'd10000;
    run_vec("sw_ovf", model(10000, 0));

    sw_count = 32'd250;
    press(4'd13);
    check("lap_on", 64'(lap), 64'd1);
    check("lap_keeps_run", 64'(sw_ctrl), 64'd1);
    sw_count = 32'd260;
    run_vec("lap_hold", model(250, 0));
    press(4'd13);
    check("lap_off", 64'(lap), 64'd0);
    run_vec("lap_track", model(260, 0));

    press(4'd13);
    press(4'd10);
    check("clear_pulse", 64'(sw_ctrl), 64'd2);
    check("clear_lap", 64'(lap), 64'd0);
    tick();
    check("clear_then_hold", 64'(sw_ctrl), 64'd0);

    // Mode change mid-conversion aborts and blanks.
    wait_upd();
    repeat (5) tick();
    check("busy_before_abort", 64'(busy), 64'd1);
    calc_result = 32'd5; calc_neg = 1'b0;
    press(4'd14);
    check("abort_mode", 64'(mode), 64'd0);
    check("abort_blank", 64'(digits), 64'hBBBB);
    check("abort_no_upd", 64'(upd), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    exp_q.push_back(model(5, 0));
    edges_to_upd(n);
    check("abort_restart_latency", 64'(n), 64'(W + 2));
    e = exp_q.pop_front();
    check("abort_new_value", 64'(digits), 64'(e));

    // Asynchronous reset mid-conversion from a non-reset state.
    press(4'd13);
    press(4'd11);
    press(4'd13);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    calc_result = 32'd42;
    repeat (3) tick();
    exp_q.push_back(model(42, 0));
    rst_n = 1'b1;
    edges_to_upd(n);
    check("post_rst_latency", 64'(n), 64'(W + 2));
    e = exp_q.pop_front();
    check("post_rst_value", 64'(digits), 64'(e));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
